// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates N_TERMS products into an ACC_W-bit sum.
// Optional MAC_SAT_EN: saturate to all-ones on carry-out instead of wrapping.
module mac_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [15:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       term_cnt,
  output logic             overflow
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LAST = 8'(N_TERMS - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic             accept;

  // next-state: clear, then handshake, then accept
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    accept  = prod_valid && (state_q == ACCUM);
    sum     = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod};
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == HOLD && out_ready) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      cnt_d = cnt_q + 8'd1;
      if (sum[ACC_W]) ovf_d = 1'b1;
`ifdef MAC_SAT_EN
      // once saturated, hold all-ones for the rest of the frame
      if (sum[ACC_W] || ovf_q) acc_d = '1;
      else acc_d = sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
      if (cnt_q == LAST) state_d = HOLD;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign prod_ready = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign acc_out    = acc_q;
  assign term_cnt   = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed checks on three parameterisations.
// Expected values are hand-computed from the product sequences.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // u0: defaults
  logic        c0 = 0, v0 = 0, or0 = 0;
  logic [15:0] p0 = 0;
  logic        r0, ov0, f0;
  logic [23:0] a0;
  logic [7:0]  t0;

  // u1: ACC_W=17 overflow
  logic        c1 = 0, v1 = 0, or1 = 0;
  logic [15:0] p1 = 0;
  logic        r1, ov1, f1;
  logic [16:0] a1;
  logic [7:0]  t1;

  // u2: N_TERMS=1
  logic        c2 = 0, v2 = 0, or2 = 0;
  logic [15:0] p2 = 0;
  logic        r2, ov2, f2;
  logic [23:0] a2;
  logic [7:0]  t2;

  mac_accumulator u0 (
    .clk(clk), .rst(rst), .clear(c0),
    .prod(p0), .prod_valid(v0), .prod_ready(r0),
    .acc_out(a0), .out_valid(ov0), .out_ready(or0),
    .term_cnt(t0), .overflow(f0)
  );

  mac_accumulator #(.N_TERMS(4), .ACC_W(17)) u1 (
    .clk(clk), .rst(rst), .clear(c1),
    .prod(p1), .prod_valid(v1), .prod_ready(r1),
    .acc_out(a1), .out_valid(ov1), .out_ready(or1),
    .term_cnt(t1), .overflow(f1)
  );

  mac_accumulator #(.N_TERMS(1), .ACC_W(24)) u2 (
    .clk(clk), .rst(rst), .clear(c2),
    .prod(p2), .prod_valid(v2), .prod_ready(r2),
    .acc_out(a2), .out_valid(ov2), .out_ready(or2),
    .term_cnt(t2), .overflow(f2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic feed0(input logic [15:0] v);
    p0 = v; v0 = 1'b1;
    step();
    v0 = 1'b0;
  endtask

  logic [31:0] held;

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_acc", 32'(a0), 0);
    chk("rst_cnt", 32'(t0), 0);
    chk("rst_ovf", 32'(f0), 0);
    chk("rst_oval", 32'(ov0), 0);
    chk("rst_rdy", 32'(r0), 1);

    // default frame, back-to-back
    v0 = 1'b1;
    p0 = 16'd50;    step();
    chk("acc1", 32'(a0), 50);
    chk("cnt1", 32'(t0), 1);
    p0 = 16'd225;   step();
    p0 = 16'd0;     step();
    chk("oval3", 32'(ov0), 0);
    p0 = 16'd65025; step();
    v0 = 1'b0;
    chk("oval4", 32'(ov0), 1);
    chk("acc4", 32'(a0), 65300);
    chk("cnt4", 32'(t0), 4);
    chk("ovf4", 32'(f0), 0);
    chk("rdy4", 32'(r0), 0);

    // backpressure with a refused product offered
    held = 32'(a0);
    v0 = 1'b1; p0 = 16'd999;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_acc", 32'(a0), held);
      chk("hold_cnt", 32'(t0), 4);
    end
    v0 = 1'b0; or0 = 1'b1;
    step();
    or0 = 1'b0;
    chk("hs_acc", 32'(a0), 0);
    chk("hs_cnt", 32'(t0), 0);
    chk("hs_rdy", 32'(r0), 1);
    chk("hs_oval", 32'(ov0), 0);

    // frame with valid gaps
    feed0(16'd1); step();
    feed0(16'd2); step(); step();
    chk("gap_acc", 32'(a0), 3);
    feed0(16'd3);
    feed0(16'd4);
    chk("gap_sum", 32'(a0), 10);
    chk("gap_oval", 32'(ov0), 1);
    or0 = 1'b1; step(); or0 = 1'b0;

    // clear mid-frame drops the offered product
    feed0(16'd50);
    feed0(16'd225);
    c0 = 1'b1; v0 = 1'b1; p0 = 16'd1000;
    step();
    c0 = 1'b0; v0 = 1'b0;
    chk("clr_acc", 32'(a0), 0);
    chk("clr_cnt", 32'(t0), 0);
    for (int i = 0; i < 4; i++) feed0(16'd1);
    chk("clr_sum", 32'(a0), 4);
    chk("clr_oval", 32'(ov0), 1);

    // clear while holding discards the result
    c0 = 1'b1; step(); c0 = 1'b0;
    chk("clrh_oval", 32'(ov0), 0);
    chk("clrh_acc", 32'(a0), 0);

    // reset mid-frame
    feed0(16'd10);
    feed0(16'd20);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstm_acc", 32'(a0), 0);
    chk("rstm_cnt", 32'(t0), 0);
    chk("rstm_rdy", 32'(r0), 1);
    chk("rstm_oval", 32'(ov0), 0);

    // reset in hold
    for (int i = 0; i < 4; i++) feed0(16'd5);
    chk("rsth_pre", 32'(ov0), 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rsth_oval", 32'(ov0), 0);
    chk("rsth_rdy", 32'(r0), 1);
    chk("rsth_acc", 32'(a0), 0);
    chk("rsth_cnt", 32'(t0), 0);

    // overflow with ACC_W=17
    v1 = 1'b1; p1 = 16'd65025;
    step(); step();
    chk("ovf2_acc", 32'(a1), 130050);
    chk("ovf2_flag", 32'(f1), 0);
    step();
    chk("ovf3_flag", 32'(f1), 1);
    step();
    v1 = 1'b0;
`ifdef MAC_SAT_EN
    chk("ovf_acc", 32'(a1), 131071);
`else
    chk("ovf_acc", 32'(a1), 129028);
`endif
    chk("ovf_flag", 32'(f1), 1);
    chk("ovf_oval", 32'(ov1), 1);
    or1 = 1'b1; step(); or1 = 1'b0;
    chk("ovf_clr", 32'(f1), 0);

    // N_TERMS=1 stream with out_ready high
    or2 = 1'b1; v2 = 1'b1; p2 = 16'd7;
    step();
    p2 = 16'd9;
    chk("n1_oval_a", 32'(ov2), 1);
    chk("n1_acc_a", 32'(a2), 7);
    chk("n1_cnt_a", 32'(t2), 1);
    step();
    chk("n1_oval_b", 32'(ov2), 0);
    chk("n1_acc_b", 32'(a2), 0);
    step();
    chk("n1_oval_c", 32'(ov2), 1);
    chk("n1_acc_c", 32'(a2), 9);
    v2 = 1'b0;
    step();
    chk("n1_oval_d", 32'(ov2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
